// File: rtl/regfile_sb.sv
// 2-read/1-write register file with same-cycle write bypass, per-register busy scoreboard,
// sticky writeback-error flag and a registered debug read port.
module regfile_sb #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 4,
    parameter int                ZERO_REG = 0,
    parameter int                SP_IDX   = 14,
    parameter logic [DATA_W-1:0] SP_RESET = 32'h2000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       rd_addr_a,
    output logic [DATA_W-1:0]       rd_data_a,
    output logic                    rd_busy_a,
    input  logic [ADDR_W-1:0]       rd_addr_b,
    output logic [DATA_W-1:0]       rd_data_b,
    output logic                    rd_busy_b,
    input  logic                    alloc_en,
    input  logic [ADDR_W-1:0]       alloc_addr,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [ADDR_W-1:0]       dbg_addr,
    output logic [DATA_W-1:0]       dbg_data,
    output logic [(2**ADDR_W)-1:0]  busy_vec,
    output logic                    wb_err
);
    localparam int DEPTH = 2**ADDR_W;
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]  busy_reg;
    logic              wb_err_reg;
    logic [DATA_W-1:0] dbg_data_reg;

    // Storage is flops rather than RAM: two combinational read ports plus a reset image.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam bit HARD_ZERO = HAS_ZERO && (gi == 0);
            localparam logic [DATA_W-1:0] RESET_VAL =
                ((gi == SP_IDX) && !HARD_ZERO) ? SP_RESET : '0;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    regs_reg[gi] <= RESET_VAL;
                end else if (!HARD_ZERO && wr_en && (wr_addr == ADDR_W'(gi))) begin
                    regs_reg[gi] <= wr_data;
                end
            end

            // A new producer allocated this cycle outranks the old producer's writeback.
            always_ff @(posedge clk or posedge reset) begin
                if (reset || HARD_ZERO) begin
                    busy_reg[gi] <= 1'b0;
                end else if (alloc_en && (alloc_addr == ADDR_W'(gi))) begin
                    busy_reg[gi] <= 1'b1;
                end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                    busy_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_err_reg <= 1'b0;
        end else if (wr_en && !busy_reg[wr_addr] && !(HAS_ZERO && (wr_addr == '0))) begin
            wb_err_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbg_data_reg <= '0;
        end else begin
            dbg_data_reg <= regs_reg[dbg_addr];
        end
    end

    logic hit_a, hit_b, zero_a, zero_b;

    always_comb begin
        hit_a  = wr_en && (wr_addr == rd_addr_a);
        hit_b  = wr_en && (wr_addr == rd_addr_b);
        zero_a = HAS_ZERO && (rd_addr_a == '0);
        zero_b = HAS_ZERO && (rd_addr_b == '0);

        rd_data_a = regs_reg[rd_addr_a];
        if (zero_a) begin
            rd_data_a = '0;
        end else if (hit_a) begin
            rd_data_a = wr_data;
        end

        rd_data_b = regs_reg[rd_addr_b];
        if (zero_b) begin
            rd_data_b = '0;
        end else if (hit_b) begin
            rd_data_b = wr_data;
        end

        rd_busy_a = busy_reg[rd_addr_a] & ~hit_a;
        rd_busy_b = busy_reg[rd_addr_b] & ~hit_b;
    end

    assign busy_vec = busy_reg;
    assign wb_err   = wb_err_reg;
    assign dbg_data = dbg_data_reg;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb (ZERO_REG=1): directed scenarios followed by random traffic,
// all compared against an array/bitmask reference model of the register file.
module tb_regfile_sb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam logic [31:0] SP_VAL = 32'h2000_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, alloc_addr, wr_addr, dbg_addr;
    logic [DATA_W-1:0] rd_data_a, rd_data_b, wr_data, dbg_data;
    logic              rd_busy_a, rd_busy_b, alloc_en, wr_en, wb_err;
    logic [DEPTH-1:0]  busy_vec;

    always #5 clk = ~clk;

    regfile_sb #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .SP_IDX(14), .SP_RESET(SP_VAL)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_busy_a(rd_busy_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_busy_b(rd_busy_b),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .busy_vec(busy_vec), .wb_err(wb_err)
    );

    // Reference model: contents, outstanding-producer set, sticky error, debug latch.
    logic [31:0] m_mem [DEPTH];
    logic [15:0] m_busy;
    logic        m_err;
    logic [31:0] m_dbg;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = (i == 14) ? SP_VAL : 32'h0;
        m_busy = '0;
        m_err  = 1'b0;
        m_dbg  = '0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        if (a == 4'd0) return 32'h0;
        if (wr_en && wr_addr == a) return wr_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [3:0] a);
        return m_busy[a] && !(wr_en && wr_addr == a);
    endfunction

    // Everything below is evaluated from pre-edge model state and the inputs held over the edge.
    function automatic void model_edge();
        logic [15:0] nb;
        m_dbg = m_mem[dbg_addr];
        if (wr_en && wr_addr != 4'd0 && !m_busy[wr_addr]) m_err = 1'b1;
        nb = m_busy;
        if (wr_en) nb[wr_addr] = 1'b0;
        if (alloc_en && alloc_addr != 4'd0) nb[alloc_addr] = 1'b1;
        m_busy = nb;
        if (wr_en && wr_addr != 4'd0) m_mem[wr_addr] = wr_data;
    endfunction

    // Called just after a falling edge with inputs already applied.
    task automatic step(input string tag);
        #1;
        check({tag, ":rd_data_a"}, rd_data_a, exp_rd(rd_addr_a));
        check({tag, ":rd_data_b"}, rd_data_b, exp_rd(rd_addr_b));
        check({tag, ":rd_busy_a"}, 32'(rd_busy_a), 32'(exp_busy(rd_addr_a)));
        check({tag, ":rd_busy_b"}, 32'(rd_busy_b), 32'(exp_busy(rd_addr_b)));
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ":busy_vec"}, 32'(busy_vec), 32'(m_busy));
        check({tag, ":wb_err"}, 32'(wb_err), 32'(m_err));
        check({tag, ":dbg_data"}, dbg_data, m_dbg);
        $display("%s wr=%b wa=%0d wd=%h al=%b aa=%0d ra=%0d rb=%0d busy=%h err=%b dbg=%h",
                 tag, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, rd_addr_a, rd_addr_b,
                 busy_vec, wb_err, dbg_data);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; held over one edge that carries a write and alloc.
    task automatic do_reset();
        wr_en = 1'b0;
        alloc_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rst:busy_vec", 32'(busy_vec), 32'h0);
        check("rst:wb_err", 32'(wb_err), 32'h0);
        check("rst:dbg_data", dbg_data, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr_a = i[3:0];
            rd_addr_b = 4'(15 - i);
            #1;
            check("rst:reg_a", rd_data_a, m_mem[i]);
            check("rst:reg_b", rd_data_b, m_mem[15 - i]);
        end
        wr_en = 1'b1; wr_addr = 4'd14; wr_data = $urandom;
        alloc_en = 1'b1; alloc_addr = 4'd5;
        @(posedge clk);
        #1;
        wr_en = 1'b0; alloc_en = 1'b0; rd_addr_a = 4'd14;
        #1;
        check("rst:no_write", rd_data_a, SP_VAL);
        check("rst:no_alloc", 32'(busy_vec), 32'h0);
        $display("reset sequence done busy=%h err=%b", busy_vec, wb_err);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rd_addr_a = 4'd14; rd_addr_b = 4'd3; alloc_en = 1'b0; alloc_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; dbg_addr = '0;
        model_reset();
        #1;
        check("init:rd_sp", rd_data_a, SP_VAL);
        check("init:rd_r3", rd_data_b, 32'h0);
        check("init:busy_vec", 32'(busy_vec), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Alloc r5, with debug port pointed at the stack pointer.
        dbg_addr = 4'd14; alloc_en = 1'b1; alloc_addr = 4'd5; rd_addr_a = 4'd5;
        step("alloc5");
        check("dbg_sp", dbg_data, SP_VAL);
        alloc_en = 1'b0;
        #1 check("busy5_seen", 32'(rd_busy_a), 32'h1);
        step("hold5");
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'd7;
        #1 check("wb5_busy_bypass", 32'(rd_busy_a), 32'h0);
        check("wb5_data_bypass", rd_data_a, 32'd7);
        step("wb5");
        check("busy5_cleared", 32'(busy_vec[5]), 32'h0);

        // Alloc and writeback on the same busy register: the new producer keeps it busy.
        wr_en = 1'b0; alloc_en = 1'b1; alloc_addr = 4'd6; rd_addr_a = 4'd6;
        step("alloc6");
        wr_en = 1'b1; wr_addr = 4'd6; wr_data = 32'd9;
        step("alloc6_wb6");
        check("busy6_kept", 32'(busy_vec[6]), 32'h1);
        check("no_err_yet", 32'(wb_err), 32'h0);
        wr_en = 1'b0; alloc_en = 1'b0;
        #1 check("r6_stored", rd_data_a, 32'd9);
        step("read6");

        // Unallocated writeback: bypass, storage and sticky error.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEAD_BEEF; rd_addr_a = 4'd3;
        #1 check("r3_bypass", rd_data_a, 32'hDEAD_BEEF);
        step("wb3");
        check("err_set", 32'(wb_err), 32'h1);
        wr_en = 1'b0;
        #1 check("r3_stored", rd_data_a, 32'hDEAD_BEEF);
        step("read3");
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'd1; rd_addr_b = 4'd7;
        step("wb7");
        wr_en = 1'b0;
        step("idle");
        check("err_sticky", 32'(wb_err), 32'h1);
        check("r7_stored", rd_data_b, 32'd1);

        // Hard-wired zero register ignores write and alloc.
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h55; alloc_en = 1'b1; alloc_addr = 4'd0;
        rd_addr_a = 4'd0; rd_addr_b = 4'd0;
        #1 check("r0_bypass_zero", rd_data_a, 32'h0);
        step("zero");
        check("busy0_zero", 32'(busy_vec[0]), 32'h0);
        check("err_unchanged", 32'(wb_err), 32'h1);

        do_reset();

        for (int n = 0; n < 400; n++) begin
            if (n % 100 == 60) do_reset();
            rd_addr_a  = 4'($urandom_range(0, 15));
            rd_addr_b  = 4'($urandom_range(0, 15));
            wr_en      = 1'($urandom_range(0, 1));
            wr_addr    = 4'($urandom_range(0, 15));
            wr_data    = $urandom;
            alloc_en   = 1'($urandom_range(0, 1));
            alloc_addr = 4'($urandom_range(0, 15));
            dbg_addr   = 4'($urandom_range(0, 15));
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
